adc0808_responder: RTL

//  Synthesizable model of the ADC0808 side of the ADC control interface: the

---
 rtl/adc0808_pkg.sv | 31 +++
 rtl/adc0808_responder_if.sv | 30 +++
 rtl/adc_edge_detect.sv | 31 +++
 rtl/adc0808_responder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/adc0808_pkg.sv
// adc0808_pkg
//   Shared definitions for the ADC0808 responder model: bus geometry,
//   default conversion timing, FSM state encoding and a channel-select
//   helper used to pick one byte out of the flattened channel bus.
package adc0808_pkg;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // 100 us conversion and 2 us start-to-eoc delay at 100 MHz.
  localparam int DEF_CONV_CYCLES = 10000;
  localparam int DEF_EOC_DELAY   = 200;
  localparam int DEF_CNT_W       = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_CONV  = 2'd3
  } state_t;

  // Channel n occupies values[8n+7:8n].
  function automatic logic [DATA_W-1:0] channel_byte(
    input logic [NUM_CH*DATA_W-1:0] values,
    input logic [ADDR_W-1:0]        ch
  );
    return values[int'(ch)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/adc0808_responder_if.sv
// adc0808_responder_if
//   Signal bundle between the FPGA-side ADC controller (master) and the
//   ADC0808 responder (slave).
//   master drives : ale, start, oe, addr, ch_values (loopback channel data)
//   slave drives  : eoc, data_out, data_oe, busy, conv_done
interface adc0808_responder_if;
  import adc0808_pkg::*;

  logic                     ale;
  logic                     start;
  logic                     oe;
  logic [ADDR_W-1:0]        addr;
  logic [NUM_CH*DATA_W-1:0] ch_values;
  logic                     eoc;
  logic [DATA_W-1:0]        data_out;
  logic                     data_oe;
  logic                     busy;
  logic                     conv_done;

  modport master (
    output ale, start, oe, addr, ch_values,
    input  eoc, data_out, data_oe, busy, conv_done
  );

  modport slave (
    input  ale, start, oe, addr, ch_values,
    output eoc, data_out, data_oe, busy, conv_done
  );

endinterface

// File: rtl/adc_edge_detect.sv
// adc_edge_detect
//   Registers a synchronous level and reports its rising and falling edges
//   relative to the previous clock.
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset (clears the history register)
//   d    in  : level to watch
//   q    out : registered copy of d
//   rise out : d & ~q
//   fall out : ~d & q
module adc_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  // History register holding last clock's level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;
  assign fall = ~d & q;

endmodule

// File: rtl/adc0808_responder.sv
// adc0808_responder
//   Behavioural stand-in for an ADC0808 chip, answering the FPGA-side ADC
//   controller for loopback and bring-up. Latches a channel address on ale,
//   runs a timed conversion after a start pulse (eoc drops EOC_DELAY clocks
//   after start falls, rises again CONV_CYCLES later) and returns the sampled
//   byte on data_out while oe is high.
//   CLK100MHZ in : system clock
//   reset     in : asynchronous active-high reset
//   bus       slave modport of adc0808_responder_if
//     ale/start/oe/addr/ch_values in, eoc/data_out/data_oe/busy/conv_done out
module adc0808_responder
  import adc0808_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int EOC_DELAY   = DEF_EOC_DELAY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                CLK100MHZ,
  input  logic                reset,
  adc0808_responder_if.slave  bus
);

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(EOC_DELAY - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_latch;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] data_gated;
  logic              eoc;
  logic              busy;
  logic              conv_done;

  logic start_q;
  logic start_rise;
  logic start_fall;
  logic ale_q;
  logic ale_rise;
  logic ale_fall;
  logic unused_edges;

  adc_edge_detect u_start_edge (
    .clk  (CLK100MHZ),
    .rst  (reset),
    .d    (bus.start),
    .q    (start_q),
    .rise (start_rise),
    .fall (start_fall)
  );

  adc_edge_detect u_ale_edge (
    .clk  (CLK100MHZ),
    .rst  (reset),
    .d    (bus.ale),
    .q    (ale_q),
    .rise (ale_rise),
    .fall (ale_fall)
  );

  // The address latch is level-transparent, so only start's edges matter.
  assign unused_edges = start_q ^ ale_q ^ ale_rise ^ ale_fall;

  // Transparent-while-high address latch, realised as a clocked load.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      addr_latch <= 3'd0;
    end else if (bus.ale) begin
      addr_latch <= bus.addr;
    end else begin
      addr_latch <= addr_latch;
    end
  end

  // An ale pulse coincident with the start fall wins over the stored address.
  always_comb begin
    addr_sel = addr_latch;
    if (bus.ale) begin
      addr_sel = bus.addr;
    end else begin
      addr_sel = addr_latch;
    end
  end

  // Conversion FSM with its counter, sample/result registers and status flags.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sample    <= 8'h00;
      result    <= 8'h00;
      eoc       <= 1'b1;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        ST_ARMED: begin
          // SAR held in reset while start stays high.
          if (start_fall) begin
            state  <= ST_DELAY;
            sample <= channel_byte(bus.ch_values, addr_sel);
            cnt    <= '0;
          end
        end
        ST_DELAY: begin
          if (start_rise) begin
            state <= ST_ARMED;
            eoc   <= 1'b1;
            cnt   <= '0;
          end else if (cnt == DELAY_LAST) begin
            state <= ST_CONV;
            eoc   <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CONV: begin
          if (start_rise) begin
            // Abort: the previous result stays visible, no completion pulse.
            state <= ST_ARMED;
            eoc   <= 1'b1;
            cnt   <= '0;
          end else if (cnt == CONV_LAST) begin
            state     <= ST_IDLE;
            result    <= sample;
            eoc       <= 1'b1;
            busy      <= 1'b0;
            conv_done <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          eoc   <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output gating follows oe combinationally so the pins tri-state promptly.
  always_comb begin
    data_gated = 8'h00;
    if (bus.oe) begin
      data_gated = result;
    end else begin
      data_gated = 8'h00;
    end
  end

  assign bus.data_out  = data_gated;
  assign bus.data_oe   = bus.oe;
  assign bus.eoc       = eoc;
  assign bus.busy      = busy;
  assign bus.conv_done = conv_done;

endmodule
